// File: rtl/layer_pkg.sv
// ---------------------------------------------------------------------------
// layer_pkg : shared types and constants for the layer priority arbiter. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package layer_pkg;

  localparam int NUM_LAYERS = 10;
  localparam int IDX_W      = 4;

  localparam int LYR_SCR = 0;
  localparam int LYR_LIV = 1;
  localparam int LYR_LRR = 2;
  localparam int LYR_INV = 3;
  localparam int LYR_PLR = 4;
  localparam int LYR_BTP = 5;
  localparam int LYR_BTI = 6;
  localparam int LYR_BLK = 7;
  localparam int LYR_SMG = 8;
  localparam int LYR_EMG = 9;

  typedef logic [IDX_W-1:0] layer_idx_t;
  typedef layer_idx_t [NUM_LAYERS-1:0] prio_table_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } arb_state_t;

  // Entries at or above this value mark an empty slot.
  localparam layer_idx_t LAYER_LIMIT = layer_idx_t'(NUM_LAYERS);

  function automatic prio_table_t identity_table();
    prio_table_t t;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      t[i] = layer_idx_t'(i);
    end
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/layer_prio_encoder.sv
// ---------------------------------------------------------------------------
// layer_prio_encoder : first-hit scan of a priority table against requests. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module layer_prio_encoder
  import layer_pkg::*;
(
  input  prio_table_t             table_i,
  input  logic [NUM_LAYERS-1:0]   eff_req_i,
  output logic                    hit_o,
  output layer_idx_t              idx_o
);

  logic [2**IDX_W-1:0] req_pad;

  // Scan from the lowest priority upward so the last assignment is slot 0's.
  always_comb begin
    req_pad                   = '0;
    req_pad[NUM_LAYERS-1:0]   = eff_req_i;
    hit_o                     = 1'b0;
    idx_o                     = '0;
    for (int s = NUM_LAYERS - 1; s >= 0; s--) begin
      if ((table_i[s] < LAYER_LIMIT) && req_pad[table_i[s]]) begin
        hit_o = 1'b1;
        idx_o = table_i[s];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/layer_arbiter.sv
// ---------------------------------------------------------------------------
// layer_arbiter : per-pixel sprite layer scheduler with frame-synchronous table swap. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module layer_arbiter
  import layer_pkg::*;
#(
  parameter int BLINK_FRAMES = 16
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic [NUM_LAYERS-1:0] layerReq,
  input  logic [NUM_LAYERS-1:0] blinkEn,
  input  logic                  cfgValid,
  output logic                  cfgReady,
  input  logic [IDX_W-1:0]      cfgSlot,
  input  logic [IDX_W-1:0]      cfgLayer,
  input  logic                  cfgCommit,
  output logic                  commitPending,
  output logic                  winValid,
  output logic [IDX_W-1:0]      winLayer,
  output logic                  bgSel,
  output logic                  blinkPhase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  arb_state_t             state_q, state_d;
  prio_table_t            active_q, shadow_q;
  logic [CNT_W-1:0]       frame_cnt_q;
  logic                   blink_q;
  logic                   win_valid_q;
  layer_idx_t             win_layer_q;

  logic [NUM_LAYERS-1:0]  eff_req;
  logic                   enc_hit;
  layer_idx_t             enc_idx;
  logic                   cfg_fire;
  logic                   swap;

  assign eff_req  = layerReq & ~(blinkEn & {NUM_LAYERS{blink_q}});
  assign cfg_fire = cfgValid & cfgReady;
  assign swap     = (state_q == ARMED) & startOfFrame;

  layer_prio_encoder u_enc (
    .table_i   (active_q),
    .eff_req_i (eff_req),
    .hit_o     (enc_hit),
    .idx_o     (enc_idx)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A commit seen together with startOfFrame in IDLE only arms; the swap waits a frame.
  always_comb begin
    state_d       = state_q;
    cfgReady      = 1'b0;
    commitPending = 1'b0;
    case (state_q)
      IDLE: begin
        cfgReady = 1'b1;
        if (cfgCommit) state_d = ARMED;
      end
      ARMED: begin
        commitPending = 1'b1;
        if (startOfFrame) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      active_q <= identity_table();
      shadow_q <= identity_table();
    end else begin
      if (swap) active_q <= shadow_q;
      if (cfg_fire && (cfgSlot < LAYER_LIMIT)) shadow_q[cfgSlot] <= cfgLayer;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (startOfFrame) begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      win_valid_q <= 1'b0;
      win_layer_q <= '0;
    end else begin
      win_valid_q <= enc_hit;
      if (enc_hit) win_layer_q <= enc_idx;
    end
  end

  assign winValid   = win_valid_q;
  assign winLayer   = win_layer_q;
  assign bgSel      = ~win_valid_q;
  assign blinkPhase = blink_q;

endmodule

`default_nettype wire

// File: tb/tb_layer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_layer_arbiter : scoreboard bench with a behavioural priority/blink/commit model. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_layer_arbiter;
  import layer_pkg::*;

  localparam int BF = 16;

  logic                  clk = 1'b0;
  logic                  resetN;
  logic                  startOfFrame;
  logic [NUM_LAYERS-1:0] layerReq;
  logic [NUM_LAYERS-1:0] blinkEn;
  logic                  cfgValid;
  logic                  cfgReady;
  logic [IDX_W-1:0]      cfgSlot;
  logic [IDX_W-1:0]      cfgLayer;
  logic                  cfgCommit;
  logic                  commitPending;
  logic                  winValid;
  logic [IDX_W-1:0]      winLayer;
  logic                  bgSel;
  logic                  blinkPhase;

  always #5 clk = ~clk;

  layer_arbiter #(.BLINK_FRAMES(BF)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .layerReq      (layerReq),
    .blinkEn       (blinkEn),
    .cfgValid      (cfgValid),
    .cfgReady      (cfgReady),
    .cfgSlot       (cfgSlot),
    .cfgLayer      (cfgLayer),
    .cfgCommit     (cfgCommit),
    .commitPending (commitPending),
    .winValid      (winValid),
    .winLayer      (winLayer),
    .bgSel         (bgSel),
    .blinkPhase    (blinkPhase)
  );

  typedef struct {
    bit wv;
    int wl;
    bit cr;
    bit cp;
    bit bp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: ordered lists of layer numbers, commit flag, frame count.
  int m_act[NUM_LAYERS];
  int m_shd[NUM_LAYERS];
  bit m_armed;
  bit m_phase;
  int m_frames;
  int m_last;

  function automatic void model_reset();
    for (int i = 0; i < NUM_LAYERS; i++) begin
      m_act[i] = i;
      m_shd[i] = i;
    end
    m_armed  = 1'b0;
    m_phase  = 1'b0;
    m_frames = 0;
    m_last   = 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [NUM_LAYERS-1:0] req, input logic [NUM_LAYERS-1:0] ben,
                       input logic sof, input logic v, input logic [3:0] slot,
                       input logic [3:0] lay, input logic com);
    exp_t e;
    @(negedge clk);
    layerReq     = req;
    blinkEn      = ben;
    startOfFrame = sof;
    cfgValid     = v;
    cfgSlot      = slot;
    cfgLayer     = lay;
    cfgCommit    = com;

    e.wv = 1'b0;
    e.wl = m_last;
    for (int s = 0; s < NUM_LAYERS; s++) begin
      if (m_act[s] < NUM_LAYERS && req[m_act[s]] && !(ben[m_act[s]] && m_phase)) begin
        e.wv = 1'b1;
        e.wl = m_act[s];
        break;
      end
    end
    m_last = e.wl;

    if (v && !m_armed && int'(slot) < NUM_LAYERS) m_shd[slot] = int'(lay);
    if (m_armed && sof) begin
      m_act   = m_shd;
      m_armed = 1'b0;
    end else if (!m_armed && com) begin
      m_armed = 1'b1;
    end
    if (sof) begin
      if (m_frames == BF - 1) begin
        m_frames = 0;
        m_phase  = !m_phase;
      end else begin
        m_frames++;
      end
    end
    e.cr = !m_armed;
    e.cp = m_armed;
    e.bp = m_phase;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic check_reset_values();
    check("rst_winValid", winValid, 0);
    check("rst_winLayer", winLayer, 0);
    check("rst_bgSel", bgSel, 1);
    check("rst_cfgReady", cfgReady, 1);
    check("rst_commitPending", commitPending, 0);
    check("rst_blinkPhase", blinkPhase, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetN = 1'b0;
    layerReq = '0; blinkEn = '0; startOfFrame = 1'b0;
    cfgValid = 1'b0; cfgCommit = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("winValid", winValid, e.wv);
        check("winLayer", winLayer, e.wl);
        check("bgSel", bgSel, !e.wv);
        check("cfgReady", cfgReady, e.cr);
        check("commitPending", commitPending, e.cp);
        check("blinkPhase", blinkPhase, e.bp);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    resetN = 1'b0;
    layerReq = '0; blinkEn = '0; startOfFrame = 1'b0;
    cfgValid = 1'b0; cfgSlot = '0; cfgLayer = '0; cfgCommit = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values();
    resetN = 1'b1;

    // Basic priority then release to background.
    drive(10'b00_0101_0000, '0, 0, 0, 0, 0, 0);
    drive('0, '0, 0, 0, 0, 0, 0);

    // Reorder 0 and 9, commit mid-frame, swap at frame start.
    drive('0, '0, 0, 1, 4'd0, 4'd9, 0);
    drive('0, '0, 0, 1, 4'd9, 4'd0, 1);
    for (int i = 0; i < 3; i++) drive(10'b10_0000_0001, '0, 0, 0, 0, 0, 0);
    drive(10'b10_0000_0001, '0, 1, 0, 0, 0, 0);
    drive(10'b10_0000_0001, '0, 0, 0, 0, 0, 0);
    drive(10'b10_0000_0001, '0, 0, 0, 0, 0, 0);

    // Writes stall while armed, then complete after the swap.
    drive('0, '0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(10'b00_1000_0100, '0, 0, 1, 4'd2, 4'd7, 0);
    drive(10'b00_1000_0100, '0, 1, 0, 0, 0, 0);
    drive(10'b00_1000_0100, '0, 0, 1, 4'd2, 4'd7, 1);
    drive(10'b00_0000_0100, '0, 1, 0, 0, 0, 0);
    drive(10'b00_0000_0100, '0, 0, 0, 0, 0, 0);
    drive(10'b00_1000_0000, '0, 0, 0, 0, 0, 0);

    // Blink masking across two half-periods.
    pulse_reset();
    for (int i = 0; i < 2 * BF; i++) begin
      drive(10'b00_0000_1000, 10'b00_0000_1000, 1, 0, 0, 0, 0);
      drive(10'b00_0000_1000, 10'b00_0000_1000, 0, 0, 0, 0, 0);
    end

    // Empty slots and a layer removed from the table.
    drive('0, '0, 0, 1, 4'd0, 4'd12, 1);
    drive(10'b00_0000_0011, '0, 1, 0, 0, 0, 0);
    drive(10'b00_0000_0001, '0, 0, 0, 0, 0, 0);
    drive(10'b00_0000_0011, '0, 0, 1, 4'd1, 4'd12, 1);
    drive(10'b00_0000_0011, '0, 1, 0, 0, 0, 0);
    drive(10'b00_0000_0011, '0, 0, 0, 0, 0, 0);
    drive('0, '0, 0, 1, 4'd14, 4'd3, 0);

    // Reset while armed discards the commit and restores identity.
    drive('0, '0, 0, 1, 4'd0, 4'd5, 1);
    idle(1);
    pulse_reset();
    drive('0, '0, 1, 0, 0, 0, 0);
    drive(10'b10_0010_0001, '0, 0, 0, 0, 0, 0);
    drive(10'b10_0010_0000, '0, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(NUM_LAYERS'($urandom), NUM_LAYERS'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
            4'($urandom), 4'($urandom_range(0, 11)), ($urandom_range(0, 15) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
